// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with rsp_err.
module riscv_lsu #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] data_addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{~uns & b[7]}}, b};
      2'b01:   res = {{16{~uns & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: res[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        we_r, uns_r, err_r, we_n, uns_n, err_n;
  logic [1:0]  size_r, size_n;
  logic [31:0] addr_r, wdata_r, rword_r, addr_n, wdata_n, rword_n;
  logic        accept_s, misalign_s, req_err_s;
  logic        rdy_s, rd_s, wr_s, vld_s, err_o_s;
  logic [31:0] rdata_s, daddr_s, wdata_o_s;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign accept_s  = req_valid && (state_r == ST_IDLE);
  assign req_err_s = (req_size == 2'b11) || misalign_s;

  // Transaction context as it will be after this edge (lets outputs be registered).
  always_comb begin
    if (accept_s) begin
      we_n = req_we; size_n = req_size; uns_n = req_unsigned;
      addr_n = req_addr; wdata_n = req_wdata; err_n = req_err_s;
    end else begin
      we_n = we_r; size_n = size_r; uns_n = uns_r;
      addr_n = addr_r; wdata_n = wdata_r; err_n = err_r;
    end
    if (accept_s) begin
      rword_n = 32'd0;
    end else if ((state_r == ST_WAIT) && (cnt_r == 4'd0)) begin
      rword_n = read_data;
    end else begin
      rword_n = rword_r;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s)                 state_s = ST_IDLE;
        else if (req_err_s)            state_s = ST_RESP;
        else if (!req_we)              state_s = ST_RD;
        else if (req_size == 2'b10)    state_s = ST_WR;
        else                           state_s = ST_RD;
      end
      ST_RD: begin
        state_s = ST_WAIT;
        cnt_s   = WAIT_INIT;
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) state_s = we_r ? ST_WR : ST_RESP;
        else               cnt_s   = cnt_r - 4'd1;
      end
      ST_WR:   state_s = ST_RESP;
      ST_RESP: state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    rdy_s   = (state_s == ST_IDLE);
    rd_s    = (state_s == ST_RD);
    wr_s    = (state_s == ST_WR);
    vld_s   = (state_s == ST_RESP);
    err_o_s = (state_s == ST_RESP) && err_n;
    if (state_s == ST_IDLE) daddr_s = 32'd0;
    else                    daddr_s = {addr_n[31:2], 2'b00};
    if ((state_s == ST_IDLE) || !we_n || err_n) wdata_o_s = 32'd0;
    else wdata_o_s = store_merge(rword_n, wdata_n, size_n, addr_n[1:0]);
    if ((state_s == ST_RESP) && !we_n && !err_n)
      rdata_s = load_extract(rword_n, size_n, addr_n[1:0], uns_n);
    else
      rdata_s = 32'd0;
  end

  // State register and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Captured request fields and the fetched memory word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r <= 1'b0; size_r <= 2'b00; uns_r <= 1'b0; err_r <= 1'b0;
      addr_r <= 32'd0; wdata_r <= 32'd0; rword_r <= 32'd0;
    end else begin
      we_r <= we_n; size_r <= size_n; uns_r <= uns_n; err_r <= err_n;
      addr_r <= addr_n; wdata_r <= wdata_n; rword_r <= rword_n;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready <= 1'b1; mem_read <= 1'b0; mem_write <= 1'b0;
      rsp_valid <= 1'b0; rsp_err <= 1'b0; rsp_rdata <= 32'd0;
      data_addr <= 32'd0; write_data <= 32'd0;
    end else begin
      req_ready <= rdy_s; mem_read <= rd_s; mem_write <= wr_s;
      rsp_valid <= vld_s; rsp_err <= err_o_s; rsp_rdata <= rdata_s;
      data_addr <= daddr_s; write_data <= wdata_o_s;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu: two instances (RD_LAT 1 and 4) against a word-array memory model.
module tb_riscv_lsu;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err [N];
  logic        mem_read [N];
  logic        mem_write [N];
  logic [31:0] data_addr [N];
  logic [31:0] write_data [N];
  logic [31:0] read_data [N];

  logic [31:0] model_mem [N][64];
  logic [31:0] bfm_mem [N][64];
  int          rd_cnt [N];
  int          rd_idx [N];
  int          n_cmp = 0;
  int          n_bad = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    riscv_lsu #(.RD_LAT(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .data_addr(data_addr[g]), .write_data(write_data[g]), .read_data(read_data[g])
    );
  end

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_word(input int k, input logic [31:0] addr, input logic [31:0] val);
    model_mem[k][addr[7:2]] = val;
    bfm_mem[k][addr[7:2]]   = val;
  endtask

  task automatic scramble_req();
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Data memory: returns the word only in the cycle RD_LAT after the read strobe, noise otherwise.
  initial begin
    for (int k = 0; k < N; k++) begin
      rd_cnt[k] = 0; rd_idx[k] = 0; read_data[k] = 32'd0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        read_data[k] = $urandom;
        if (reset) begin
          rd_cnt[k] = 0;
        end else begin
          if (mem_write[k]) bfm_mem[k][data_addr[k][7:2]] = write_data[k];
          if (rd_cnt[k] != 0) begin
            rd_cnt[k]--;
            if (rd_cnt[k] == 0) read_data[k] = bfm_mem[k][rd_idx[k]];
          end
          if (mem_read[k]) begin
            rd_cnt[k] = lat_of(k);
            rd_idx[k] = int'(data_addr[k][7:2]);
          end
        end
      end
    end
  end

  task automatic run_txn(input int k, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int idx, sh, hsh, n, exp_lat, exp_nrd, exp_nwr, nrd, nwr, lt;
    logic [31:0] word, exp_rd, exp_word, t;
    logic exp_err, done, both, ready_bad, addr_bad;
    idx = int'(addr[7:2]);
    lt = lat_of(k);
    word = model_mem[k][idx];
    sh = 8 * int'(addr[1:0]);
    hsh = addr[1] ? 16 : 0;
    exp_err = (size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) exp_err = 1'b1;
`endif
    exp_word = word;
    exp_rd = 32'd0;
    if (exp_err) begin
      exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
    end else if (!we) begin
      exp_lat = 2 + lt; exp_nrd = 1; exp_nwr = 0;
      if (size == 2'b00) begin
        t = (word >> sh) & 32'h0000_00FF;
        if (!uns && t[7]) t = t | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
        t = (word >> hsh) & 32'h0000_FFFF;
        if (!uns && t[15]) t = t | 32'hFFFF_0000;
      end else begin
        t = word;
      end
      exp_rd = t;
    end else if (size == 2'b10) begin
      exp_lat = 2; exp_nrd = 0; exp_nwr = 1; exp_word = wdata;
    end else begin
      exp_lat = 3 + lt; exp_nrd = 1; exp_nwr = 1;
      if (size == 2'b00)
        exp_word = (word & ~(32'h0000_00FF << sh)) | ((wdata & 32'h0000_00FF) << sh);
      else
        exp_word = (word & ~(32'h0000_FFFF << hsh)) | ((wdata & 32'h0000_FFFF) << hsh);
    end

    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_before_req", 32'(req_ready[k]), 32'd1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid[k] = 1'b1;
    n = 0; nrd = 0; nwr = 0; done = 1'b0; both = 1'b0; ready_bad = 1'b0; addr_bad = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (mem_read[k]) begin
        nrd++;
        if (data_addr[k] !== {addr[31:2], 2'b00}) addr_bad = 1'b1;
      end
      if (mem_write[k]) begin
        nwr++;
        if (data_addr[k] !== {addr[31:2], 2'b00}) addr_bad = 1'b1;
      end
      if (mem_read[k] && mem_write[k]) both = 1'b1;
      if (req_ready[k]) ready_bad = 1'b1;
      if (rsp_valid[k]) begin
        done = 1'b1;
        check_eq("rsp_rdata", rsp_rdata[k], exp_rd);
        check_eq("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
      end
      if (n == 1) begin
        req_valid[k] = 1'b0;
        scramble_req();
      end
    end
    check_eq("latency", 32'(n), 32'(exp_lat));
    check_eq("num_reads", 32'(nrd), 32'(exp_nrd));
    check_eq("num_writes", 32'(nwr), 32'(exp_nwr));
    check_eq("strobe_addr_bad", 32'(addr_bad), 32'd0);
    check_eq("strobes_overlap", 32'(both), 32'd0);
    check_eq("busy_ready_high", 32'(ready_bad), 32'd0);
    @(negedge clk);
    check_eq("idle_ready", 32'(req_ready[k]), 32'd1);
    check_eq("idle_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    check_eq("mem_word", bfm_mem[k][idx], exp_word);
    model_mem[k][idx] = exp_word;
  endtask

  task automatic reset_abort(input int k, input int pre_negs, input logic exp_rd_pre);
    logic saw_rsp;
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_0042; req_wdata = 32'h0000_00A5;
    req_valid[k] = 1'b1;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    repeat (pre_negs) @(negedge clk);
    check_eq("pre_reset_busy", 32'(req_ready[k]), 32'd0);
    check_eq("pre_reset_rd", 32'(mem_read[k]), 32'(exp_rd_pre));
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mem_read", 32'(mem_read[k]), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write[k]), 32'd0);
    check_eq("rst_ready", 32'(req_ready[k]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    saw_rsp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[k] || mem_write[k]) saw_rsp = 1'b1;
    end
    check_eq("rsp_after_abort", 32'(saw_rsp), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      for (int i = 0; i < 64; i++) begin
        model_mem[k][i] = $urandom;
        bfm_mem[k][i] = model_mem[k][i];
      end
    end
    scramble_req();
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check_eq("reset_ready", 32'(req_ready[k]), 32'd1);
      check_eq("reset_strobes", {30'd0, mem_read[k], mem_write[k]}, 32'd0);
      check_eq("reset_rsp", {30'd0, rsp_valid[k], rsp_err[k]}, 32'd0);
      check_eq("reset_rdata", rsp_rdata[k], 32'd0);
      check_eq("reset_addr", data_addr[k], 32'd0);
      check_eq("reset_wdata", write_data[k], 32'd0);
    end
    #2 reset = 1'b0;
    @(negedge clk);

    set_word(0, 32'h0000_0100, 32'hDEAD_BEEF);
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    set_word(0, 32'h0000_0103, 32'h80AA_55CC);
    run_txn(0, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
    run_txn(0, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
    set_word(0, 32'h0000_0102, 32'h1122_3344);
    run_txn(0, 1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h0000_005A);
    set_word(0, 32'h0000_0101, 32'hAAAA_5555);
    run_txn(0, 1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0);
    run_txn(0, 1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0);
    run_txn(1, 1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'hCAFE_1234);

    reset_abort(0, 1, 1'b1);
    run_txn(0, 1'b1, 2'b10, 1'b0, 32'h0000_0080, 32'h1357_9BDF);
    reset_abort(1, 3, 1'b0);
    run_txn(1, 1'b1, 2'b10, 1'b0, 32'h0000_0084, 32'h2468_ACE0);

    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0084, 32'h0);
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0088, 32'h0);
    run_txn(1, 1'b1, 2'b10, 1'b0, 32'h0000_008C, 32'h0F0F_F0F0);
    run_txn(1, 1'b1, 2'b10, 1'b0, 32'h0000_0090, 32'hF0F0_0F0F);

    for (int i = 0; i < 200; i++) begin
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom_range(0, 3)),
              1'($urandom), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit on the processor side of the data memory port. Accepts one load or store request at a time from the core pipeline and drives the word-wide data memory port (mem_read, mem_write, data_addr, write_data) toward the data memory or data BFM, which answers on read_data. Sub-word loads are extracted and extended in the unit. Sub-word stores are performed as read-modify-write, because the memory port has no byte enables.

## Interface
- RD_LAT, 1: memory read latency in cycles (legal range 1..15).
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  unit idle; request accepted on an edge where req_valid & req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  request rejected; no memory access was made.
- mem_read  output  1  read strobe, one cycle per access.
- mem_write  output  1  write strobe, one cycle per access.
- data_addr  output  32  word address {addr[31:2],2'b00}.
- write_data  output  32  full word to write.
- read_data  input  32  valid RD_LAT cycles after the mem_read cycle.

## Operation
- States:
  - IDLE: req_ready=1.
  - RD: mem_read=1 for one cycle.
  - WAIT: RD_LAT cycles, down-counter.
  - WR: mem_write=1 for one cycle.
  - RESP: rsp_valid=1 for one cycle.
- Acceptance in IDLE captures we, size, unsigned, addr and wdata.
- Transitions out of IDLE:
  - Error → RESP.
  - Load → RD.
  - Word store → WR.
  - Byte/half store → RD.
- Other transitions: RD→WAIT. At the end of the last WAIT cycle, read_data is registered; load→RESP, store→WR. WR→RESP. RESP→IDLE.
- Load extraction:
  - Byte uses lane addr[1:0].
  - Half uses lane addr[1] (bits [15:0] or [31:16]).
  - Result is extended per req_unsigned. Word loads are passed through.
- Store merge: replace the addressed byte or half of the registered read word with wdata[7:0] or wdata[15:0]; the other lanes are kept unchanged. Word store: write_data = wdata.
- data_addr and write_data hold captured values for the whole transaction and are 0 in IDLE.
- req_size=11 always yields rsp_err=1, with no mem_read and no mem_write.

## Timing
- Reset values: req_ready=1, all other outputs 0, state IDLE, counter 0.
- Reset mid-transaction aborts immediately: mem_read/mem_write drop asynchronously and no rsp_valid is produced.
- Latency is counted in edges from the acceptance edge to the edge where rsp_valid is sampled high:
  - Load: 2+RD_LAT.
  - Word store: 2.
  - Byte/half store: 3+RD_LAT.
  - Error: 1.
- req_ready is 0 from the cycle after acceptance through RESP. A new request can be accepted on the edge that ends RESP's successor IDLE cycle, so back-to-back word stores complete every 3 edges.
- req_valid is ignored outside IDLE. Request inputs may change after acceptance.
- Exactly one mem_read and/or one mem_write pulse occurs per transaction, never both in the same cycle.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]≠0, gives rsp_err=1 with no memory access.
- Undefined:
  - Misalignment is ignored. Half uses addr[1]; word uses addr[31:2].
  - The access proceeds normally and rsp_err is raised only for size 11.

## Test plan
- Word load, addr 0x100, RD_LAT=1, read_data=0xDEADBEEF → mem_read pulse with data_addr=0x100; rsp_rdata=0xDEADBEEF, rsp_valid 3 edges after acceptance.
- Byte loads at 0x103 with memory word 0x80AA55CC:
  - Signed → rsp_rdata=0xFFFFFF80.
  - Unsigned → 0x00000080.
- Byte store 0x5A to 0x102 over memory word 0x11223344 → one read, then one write with write_data=0x115A3344; rsp_valid after 4 edges, rsp_err=0.
- Half load at 0x101:
  - With LSU_MISALIGN_TRAP_EN → rsp_err=1 after 1 edge, no strobes.
  - Without it, over word 0xAAAA5555 signed → rsp_rdata=0x00005555.
- Reset asserted during WAIT of a store → strobes low immediately, no rsp_valid, req_ready=1; next word store completes normally.
- RD_LAT=4, back-to-back word loads → each rsp_valid 6 edges after its acceptance; read_data is sampled only in the last WAIT cycle.
